// File: rtl/bsg_dramsim3_req_arbiter_pkg.sv
// Shared types for the DRAMsim3 request arbiter: FSM states, pending-read entry, index helper.
package bsg_dramsim3_req_arbiter_pkg;

  // Entry fields are sized for the widest supported channel; narrower addresses are zero-extended.
  localparam int pend_addr_width_gp = 64;
  localparam int pend_id_width_gp   = 8;

  typedef logic [pend_addr_width_gp-1:0] pend_addr_t;
  typedef logic [pend_id_width_gp-1:0]   pend_id_t;

  typedef enum logic [0:0] {IDLE, ISSUE} arb_state_e;

  typedef struct packed {
    logic       v;
    pend_addr_t addr;
    pend_id_t   id;
  } pend_entry_s;

  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/bsg_dramsim3_read_pending_table.sv
// Address-keyed CAM of outstanding reads; completions look up the issuing requester id.
module bsg_dramsim3_read_pending_table
  import bsg_dramsim3_req_arbiter_pkg::*;
#(
  parameter int els_p        = 8,
  parameter int addr_width_p = 28,
  parameter int num_query_p  = 4
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      alloc_v_i,
  input  logic [addr_width_p-1:0]                   alloc_addr_i,
  input  pend_id_t                                  alloc_id_i,
  input  logic                                      lookup_v_i,
  input  logic [addr_width_p-1:0]                   lookup_addr_i,
  input  logic [num_query_p-1:0][addr_width_p-1:0]  query_addr_i,
  output logic                                      full_o,
  output logic [num_query_p-1:0]                    match_any_o,
  output logic                                      hit_o,
  output pend_id_t                                  hit_id_o
);

  pend_entry_s [els_p-1:0] ent_q, ent_d;
  logic [els_p-1:0] valid, hit_vec, alloc_oh;
  logic             found;

  always_comb begin
    found    = 1'b0;
    valid    = '0;
    hit_vec  = '0;
    alloc_oh = '0;
    for (int i = 0; i < els_p; i++) begin
      valid[i]   = ent_q[i].v;
      hit_vec[i] = lookup_v_i & ent_q[i].v & (ent_q[i].addr == pend_addr_t'(lookup_addr_i));
      if (!ent_q[i].v && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign full_o = &valid;

  // Queries see entries being freed this cycle as still present.
  always_comb begin
    match_any_o = '0;
    for (int q = 0; q < num_query_p; q++)
      for (int i = 0; i < els_p; i++)
        if (ent_q[i].v && (ent_q[i].addr == pend_addr_t'(query_addr_i[q])))
          match_any_o[q] = 1'b1;
  end

  always_comb begin
    hit_o    = 1'b0;
    hit_id_o = '0;
    for (int i = 0; i < els_p; i++)
      if (hit_vec[i]) begin
        hit_o    = 1'b1;
        hit_id_o = ent_q[i].id;
      end
  end

  // Allocation picks from the pre-free vector, so a freed slot is reusable only next cycle.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < els_p; i++) begin
      if (hit_vec[i]) ent_d[i].v = 1'b0;
      if (alloc_v_i && alloc_oh[i]) begin
        ent_d[i].v    = 1'b1;
        ent_d[i].addr = pend_addr_t'(alloc_addr_i);
        ent_d[i].id   = alloc_id_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) ent_q <= '0;
    else            ent_q <= ent_d;
  end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_req_arbiter.sv
// Round-robin share of one DRAMsim3 channel port with out-of-order read-response routing.
// Define BSG_DRAMSIM3_REQ_ARBITER_STATS_EN to add grant/stall/table-full counters.
module bsg_nonsynth_dramsim3_req_arbiter
  import bsg_dramsim3_req_arbiter_pkg::*;
#(
  parameter  int num_req_p            = 4,
  parameter  int channel_addr_width_p = 28,
  parameter  int data_width_p         = 512,
  parameter  int max_reads_p          = 8,
  localparam int mask_width_lp        = data_width_p / 8,
  localparam int id_width_lp          = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                              clk_i,
  input  logic                                              reset_n_i,
  input  logic [num_req_p-1:0]                              req_v_i,
  input  logic [num_req_p-1:0]                              req_write_not_read_i,
  input  logic [num_req_p-1:0][channel_addr_width_p-1:0]    req_addr_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]            req_data_i,
  input  logic [num_req_p-1:0][mask_width_lp-1:0]           req_mask_i,
  output logic [num_req_p-1:0]                              req_yumi_o,
  output logic [num_req_p-1:0]                              resp_v_o,
  output logic [data_width_p-1:0]                           resp_data_o,
  output logic [channel_addr_width_p-1:0]                   resp_addr_o,
  output logic                                              v_o,
  output logic                                              write_not_read_o,
  output logic [channel_addr_width_p-1:0]                   ch_addr_o,
  output logic                                              data_v_o,
  output logic [data_width_p-1:0]                           data_o,
  output logic [mask_width_lp-1:0]                          mask_o,
  input  logic                                              yumi_i,
  input  logic                                              data_yumi_i,
  input  logic                                              data_v_i,
  input  logic [data_width_p-1:0]                           data_i,
  input  logic [channel_addr_width_p-1:0]                   read_done_ch_addr_i
`ifdef BSG_DRAMSIM3_REQ_ARBITER_STATS_EN
 ,output logic [num_req_p-1:0][31:0]                        grant_count_o,
  output logic [31:0]                                       stall_count_o,
  output logic [31:0]                                       read_full_count_o
`endif
);

  arb_state_e             state_q, state_d;
  logic [id_width_lp-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [id_width_lp-1:0] pick_id, cand;
  logic                   pick_v;
  logic [num_req_p-1:0]   elig, pt_match;
  logic                   pt_full, pt_hit, alloc_v;
  pend_id_t               pt_hit_id;

  bsg_dramsim3_read_pending_table #(
    .els_p       (max_reads_p),
    .addr_width_p(channel_addr_width_p),
    .num_query_p (num_req_p)
  ) pend_tbl (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .alloc_v_i    (alloc_v),
    .alloc_addr_i (req_addr_i[grant_q]),
    .alloc_id_i   (pend_id_t'(grant_q)),
    .lookup_v_i   (data_v_i & reset_n_i),
    .lookup_addr_i(read_done_ch_addr_i),
    .query_addr_i (req_addr_i),
    .full_o       (pt_full),
    .match_any_o  (pt_match),
    .hit_o        (pt_hit),
    .hit_id_o     (pt_hit_id)
  );

  // A read waits for a free slot and for any same-address read to complete.
  always_comb begin
    for (int i = 0; i < num_req_p; i++)
      elig[i] = req_v_i[i] & (req_write_not_read_i[i] | (~pt_full & ~pt_match[i]));
  end

  // Walk offsets high to low so the nearest eligible index at/after rr_ptr wins.
  always_comb begin
    pick_v  = 1'b0;
    pick_id = '0;
    cand    = '0;
    for (int off = num_req_p - 1; off >= 0; off--) begin
      cand = id_width_lp'(wrap_idx(int'(rr_ptr_q) + off, num_req_p));
      if (elig[cand]) begin
        pick_v  = 1'b1;
        pick_id = cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    v_o              = 1'b0;
    write_not_read_o = 1'b0;
    ch_addr_o        = '0;
    data_o           = '0;
    mask_o           = '0;
    req_yumi_o       = '0;
    alloc_v          = 1'b0;
    if (reset_n_i) begin
      unique case (state_q)
        IDLE: begin
          if (pick_v) begin
            grant_d = pick_id;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          v_o              = 1'b1;
          write_not_read_o = req_write_not_read_i[grant_q];
          ch_addr_o        = req_addr_i[grant_q];
          data_o           = req_data_i[grant_q];
          mask_o           = req_mask_i[grant_q];
          if (yumi_i) begin
            req_yumi_o[grant_q] = 1'b1;
            rr_ptr_d            = id_width_lp'(wrap_idx(int'(grant_q) + 1, num_req_p));
            alloc_v             = ~req_write_not_read_i[grant_q];
            state_d             = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_v_o    = v_o & write_not_read_o;
  assign resp_v_o    = pt_hit ? ({{(num_req_p-1){1'b0}}, 1'b1} << pt_hit_id) : '0;
  assign resp_data_o = data_i;
  assign resp_addr_o = read_done_ch_addr_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef BSG_DRAMSIM3_REQ_ARBITER_STATS_EN
  logic [num_req_p-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]                stall_cnt_q, stall_cnt_d, rfull_cnt_q, rfull_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    rfull_cnt_d = rfull_cnt_q;
    for (int i = 0; i < num_req_p; i++)
      if (req_yumi_o[i] && !(&grant_cnt_q[i])) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    if ((state_q == ISSUE) && !yumi_i && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (pt_full && |(req_v_i & ~req_write_not_read_i) && !(&rfull_cnt_q))
      rfull_cnt_d = rfull_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
      rfull_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      rfull_cnt_q <= rfull_cnt_d;
    end
  end

  assign grant_count_o     = grant_cnt_q;
  assign stall_count_o     = stall_cnt_q;
  assign read_full_count_o = rfull_cnt_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (data_v_i)
        assert (pt_hit) else $error("dramsim3 arbiter: read completion for untracked addr %h", read_done_ch_addr_i);
      if (state_q == ISSUE) begin
        assert (req_v_i[grant_q]) else $error("dramsim3 arbiter: requester %0d dropped valid while granted", grant_q);
        if (req_write_not_read_i[grant_q])
          assert (data_yumi_i == yumi_i) else $error("dramsim3 arbiter: write data_yumi differs from yumi");
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_req_arbiter.sv
// Directed bench for the DRAMsim3 request arbiter: reset, read routing, round-robin, table full, same-address, reset flush.
module tb_bsg_nonsynth_dramsim3_req_arbiter;
  localparam int NR = 4, AW = 28, DW = 512, MR = 8, MW = DW / 8;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NR-1:0]          req_v, req_wnr, req_yumi, resp_v;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0][MW-1:0]  req_mask;
  logic [DW-1:0]          resp_data, data_o, data_i;
  logic [AW-1:0]          resp_addr, ch_addr, rd_addr;
  logic                   v_o, wnr_o, data_v_o, yumi, data_yumi, data_v;
  logic [MW-1:0]          mask_o;
`ifdef BSG_DRAMSIM3_REQ_ARBITER_STATS_EN
  logic [NR-1:0][31:0]    grant_cnt;
  logic [31:0]            stall_cnt, rfull_cnt;
`endif

  int errors = 0;
  int checks = 0;

  bsg_nonsynth_dramsim3_req_arbiter #(
    .num_req_p(NR), .channel_addr_width_p(AW), .data_width_p(DW), .max_reads_p(MR)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_write_not_read_i(req_wnr), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_mask_i(req_mask), .req_yumi_o(req_yumi),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_addr_o(resp_addr),
    .v_o(v_o), .write_not_read_o(wnr_o), .ch_addr_o(ch_addr),
    .data_v_o(data_v_o), .data_o(data_o), .mask_o(mask_o),
    .yumi_i(yumi), .data_yumi_i(data_yumi),
    .data_v_i(data_v), .data_i(data_i), .read_done_ch_addr_i(rd_addr)
`ifdef BSG_DRAMSIM3_REQ_ARBITER_STATS_EN
   ,.grant_count_o(grant_cnt), .stall_count_o(stall_cnt), .read_full_count_o(rfull_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req_v = '0; yumi = 1'b0; data_yumi = 1'b0; data_v = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  // Present one request with yumi held high; wait (bounded) for acceptance.
  task automatic do_req(input logic [1:0] r, input logic wr, input logic [AW-1:0] a);
    int n;
    req_v[r] = 1'b1; req_wnr[r] = wr; req_addr[r] = a;
    yumi = 1'b1; data_yumi = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!req_yumi[r] && n < 20);
    checks++;
    if (!req_yumi[r]) begin errors++; $display("FAIL do_req: req %0d addr %h not accepted, yumi=%b want bit set", r, a, req_yumi); end
    tick();
    req_v[r] = 1'b0; yumi = 1'b0; data_yumi = 1'b0;
  endtask

  task automatic test_reset();
    data_i = {16{32'h1234_5678}}; rd_addr = 28'h0ABCDEF;
    req_v = 4'b1111; req_wnr = 4'b1111;
    reset_n = 1'b0; yumi = 1'b1; data_yumi = 1'b1; data_v = 1'b0;
    tick(); tick();
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    checks++; if (req_yumi !== 4'b0000) begin errors++; $display("FAIL reset_req_yumi: got %b want 0000", req_yumi); end
    checks++; if (resp_v !== 4'b0000) begin errors++; $display("FAIL reset_resp_v: got %b want 0000", resp_v); end
    checks++; if (data_v_o !== 1'b0) begin errors++; $display("FAIL reset_data_v_o: got %b want 0", data_v_o); end
    checks++; if (ch_addr !== 28'h0) begin errors++; $display("FAIL reset_ch_addr: got %h want 0", ch_addr); end
    checks++; if (resp_addr !== 28'h0ABCDEF) begin errors++; $display("FAIL reset_resp_addr: got %h want 0abcdef", resp_addr); end
    checks++; if (resp_data[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL reset_resp_data: got %h want 12345678", resp_data[31:0]); end
    apply_reset();
  endtask

  task automatic test_single_read();
    req_v[2] = 1'b1; req_wnr[2] = 1'b0; req_addr[2] = 28'h40; yumi = 1'b0; data_yumi = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (v_o !== 1'b1 || req_yumi !== 4'b0000) begin errors++; $display("FAIL read_hold c%0d: v_o=%b yumi=%b want 1/0000", c, v_o, req_yumi); end
      tick();
    end
    checks++; if (ch_addr !== 28'h40 || wnr_o !== 1'b0 || data_v_o !== 1'b0) begin errors++; $display("FAIL read_cmd: addr=%h wnr=%b dv=%b want 40/0/0", ch_addr, wnr_o, data_v_o); end
    yumi = 1'b1; #1;
    checks++; if (req_yumi !== 4'b0100) begin errors++; $display("FAIL read_yumi: got %b want 0100", req_yumi); end
    tick(); req_v[2] = 1'b0; yumi = 1'b0;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL read_idle: v_o got %b want 0", v_o); end
    tick(); tick();
    data_v = 1'b1; rd_addr = 28'h40; data_i = {16{32'hFEED_0040}}; #1;
    checks++; if (resp_v !== 4'b0100) begin errors++; $display("FAIL read_resp_v: got %b want 0100", resp_v); end
    checks++; if (resp_data[63:32] !== 32'hFEED_0040) begin errors++; $display("FAIL read_resp_data: got %h want feed0040", resp_data[63:32]); end
    tick(); data_v = 1'b0;
  endtask

  task automatic test_rr_writes();
    logic [3:0] exp_oh;
    logic [1:0] g;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = AW'(32'h400 + 32'h40 * i);
      req_data[i] = {16{32'hCAFE_0000 + 32'(i)}};
      req_mask[i] = {8{8'(8'h11 * (i + 1))}};
    end
    req_wnr = 4'b1111; req_v = 4'b1111; yumi = 1'b1; data_yumi = 1'b1;
    for (int k = 0; k < 8; k++) begin
      g = 2'(k % 4);
      exp_oh = 4'b0001 << g;
      tick();
      checks++; if (req_yumi !== exp_oh) begin errors++; $display("FAIL rr_grant k%0d: got %b want %b", k, req_yumi, exp_oh); end
      checks++; if (data_v_o !== 1'b1 || ch_addr !== req_addr[g]) begin errors++; $display("FAIL rr_cmd k%0d: dv=%b addr=%h want 1/%h", k, data_v_o, ch_addr, req_addr[g]); end
      checks++; if (data_o !== req_data[g] || mask_o !== req_mask[g]) begin errors++; $display("FAIL rr_data k%0d: data=%h mask=%h want %h", k, data_o[31:0], mask_o[7:0], req_data[g][31:0]); end
      tick();
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rr_arb_cycle k%0d: v_o got %b want 0", k, v_o); end
    end
    req_v = '0; yumi = 1'b0; data_yumi = 1'b0;
  endtask

  task automatic test_table_full();
    apply_reset();
    for (int k = 0; k < MR; k++) do_req(2'd0, 1'b0, AW'(32'h1000 + 32'h40 * k));
    req_v[1] = 1'b1; req_wnr[1] = 1'b0; req_addr[1] = 28'h2000;
    req_v[2] = 1'b1; req_wnr[2] = 1'b1; req_addr[2] = 28'h3000;
    yumi = 1'b1; data_yumi = 1'b1;
    tick();
    checks++; if (req_yumi !== 4'b0100 || wnr_o !== 1'b1) begin errors++; $display("FAIL full_write: yumi=%b wnr=%b want 0100/1", req_yumi, wnr_o); end
    tick(); req_v[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL full_read_stall c%0d: v_o got %b want 0", c, v_o); end
    end
    data_v = 1'b1; rd_addr = 28'h1000; #1;
    checks++; if (resp_v !== 4'b0001) begin errors++; $display("FAIL full_free_resp: got %b want 0001", resp_v); end
    tick(); data_v = 1'b0;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL full_free_same_cycle: v_o got %b want 0", v_o); end
    tick();
    checks++; if (v_o !== 1'b1 || ch_addr !== 28'h2000 || req_yumi !== 4'b0010) begin errors++; $display("FAIL full_9th_read: v=%b addr=%h yumi=%b want 1/2000/0010", v_o, ch_addr, req_yumi); end
    tick(); req_v[1] = 1'b0; yumi = 1'b0; data_yumi = 1'b0;
  endtask

  task automatic test_same_addr();
    apply_reset();
    req_v[0] = 1'b1; req_wnr[0] = 1'b0; req_addr[0] = 28'h100;
    req_v[1] = 1'b1; req_wnr[1] = 1'b0; req_addr[1] = 28'h100;
    yumi = 1'b1; data_yumi = 1'b1;
    tick();
    checks++; if (req_yumi !== 4'b0001) begin errors++; $display("FAIL same_first: got %b want 0001", req_yumi); end
    tick(); req_v[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL same_blocked c%0d: v_o got %b want 0", c, v_o); end
    end
    data_v = 1'b1; rd_addr = 28'h100; #1;
    checks++; if (resp_v !== 4'b0001) begin errors++; $display("FAIL same_resp0: got %b want 0001", resp_v); end
    tick(); data_v = 1'b0;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL same_free_cycle: v_o got %b want 0", v_o); end
    tick();
    checks++; if (req_yumi !== 4'b0010 || ch_addr !== 28'h100) begin errors++; $display("FAIL same_second: yumi=%b addr=%h want 0010/100", req_yumi, ch_addr); end
    tick(); req_v[1] = 1'b0; yumi = 1'b0; data_yumi = 1'b0;
    data_v = 1'b1; rd_addr = 28'h100; #1;
    checks++; if (resp_v !== 4'b0010) begin errors++; $display("FAIL same_resp1: got %b want 0010", resp_v); end
    tick(); data_v = 1'b0;
  endtask

  task automatic test_reset_flush();
    apply_reset();
    do_req(2'd0, 1'b0, 28'h200);
    do_req(2'd1, 1'b0, 28'h240);
    do_req(2'd2, 1'b0, 28'h280);
    reset_n = 1'b0; tick();
    checks++; if (v_o !== 1'b0 || resp_v !== 4'b0000 || req_yumi !== 4'b0000) begin errors++; $display("FAIL flush_outputs: v=%b resp=%b yumi=%b want 0", v_o, resp_v, req_yumi); end
    reset_n = 1'b1;
    req_v[0] = 1'b1; req_wnr[0] = 1'b0; req_addr[0] = 28'h200;
    req_v[1] = 1'b1; req_wnr[1] = 1'b0; req_addr[1] = 28'h240;
    yumi = 1'b1; data_yumi = 1'b1;
    tick();
    checks++; if (req_yumi !== 4'b0001) begin errors++; $display("FAIL flush_reissue0: got %b want 0001", req_yumi); end
    tick(); req_v[0] = 1'b0;
    tick();
    checks++; if (req_yumi !== 4'b0010) begin errors++; $display("FAIL flush_reissue1: got %b want 0010", req_yumi); end
    tick(); req_v[1] = 1'b0; yumi = 1'b0; data_yumi = 1'b0;
  endtask

`ifdef BSG_DRAMSIM3_REQ_ARBITER_STATS_EN
  task automatic test_stats();
    apply_reset();
    req_v[1] = 1'b1; req_wnr[1] = 1'b1; req_addr[1] = 28'h500; yumi = 1'b0; data_yumi = 1'b0;
    tick();
    repeat (4) tick();
    yumi = 1'b1; data_yumi = 1'b1;
    repeat (19) tick();
    req_v[1] = 1'b0; yumi = 1'b0; data_yumi = 1'b0;
    tick();
    checks++; if (grant_cnt[1] !== 32'd10) begin errors++; $display("FAIL stats_grant: got %0d want 10", grant_cnt[1]); end
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stats_stall: got %0d want 4", stall_cnt); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; req_v = '0; req_wnr = '0; req_addr = '0; req_data = '0; req_mask = '0;
    yumi = 1'b0; data_yumi = 1'b0; data_v = 1'b0; data_i = '0; rd_addr = '0;
    test_reset();
    test_single_read();
    test_rr_writes();
    test_table_full();
    test_same_addr();
    test_reset_flush();
`ifdef BSG_DRAMSIM3_REQ_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
